reg_encoder_3x8_seq: RTL

Registered 3-to-8 one-hot driver: the inverse direction of the 8-to-3 priority/one-hot decoder used on the key/channel input side. Accepts a 3-bit index on a load strobe and drives the matching one-hot line for a programmable dwell time. In scan mode it sweeps upward from the loaded index to line 7. Sits on the output side, driving per-channel enables (LED columns, tone-channel gates) from a binary channel index.

---
 rtl/reg_encoder_3x8_seq_pkg.sv | 13 +
 rtl/reg_encoder_3x8_seq_decoder_3x8.sv | 17 +
 rtl/reg_encoder_3x8_seq.sv | 97 +++++++++
 3 files changed

// File: rtl/reg_encoder_3x8_seq_pkg.sv
// rtl/reg_encoder_3x8_seq_pkg.sv - shared encodings for the registered 3-to-8 one-hot driver
package reg_encoder_3x8_seq_pkg;

  localparam int NUM_LINES = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/reg_encoder_3x8_seq_decoder_3x8.sv
// rtl/reg_encoder_3x8_seq_decoder_3x8.sv - combinational binary-to-one-hot line decoder
module decoder_3x8
  import reg_encoder_3x8_seq_pkg::*;
(
  input  logic [IDX_W-1:0]     index,
  input  logic                 en,
  output logic [NUM_LINES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot = NUM_LINES'(1) << index;
    end
  end

endmodule

// File: rtl/reg_encoder_3x8_seq.sv
// rtl/reg_encoder_3x8_seq.sv - loads a line index and drives its one-hot enable for a dwell time,
// optionally sweeping upward to line 7
module reg_encoder_3x8_seq
  import reg_encoder_3x8_seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic                 mode,
  input  logic [IDX_W-1:0]     data_in,
  output logic [NUM_LINES-1:0] data_out,
  output logic [IDX_W-1:0]     index_out,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(DWELL_CYCLES) + 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 scan_q, scan_d;
  logic [NUM_LINES-1:0] data_out_q, onehot_d;
  logic [IDX_W-1:0]     index_out_q;
  logic                 busy_q, done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    scan_d  = scan_q;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            idx_d   = data_in;
            scan_d  = mode;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
            cnt_d = '0;
            // Advance straight to the next line with no gap; scan stops at the top line.
            if (scan_q && (idx_q != IDX_W'(NUM_LINES - 1))) begin
              idx_d = idx_q + IDX_W'(1);
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  decoder_3x8 u_decoder (
    .index  (idx_d),
    .en     (state_d == ST_HOLD),
    .onehot (onehot_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      scan_q      <= 1'b0;
      data_out_q  <= '0;
      index_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      scan_q      <= scan_d;
      data_out_q  <= onehot_d;
      index_out_q <= idx_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign data_out  = data_out_q;
  assign index_out = index_out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
